// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer.
// Holds the FSM state encoding, the command-word layout and field widths,
// and the default values of the block parameters.
package spi_cmd_sequencer_pkg;

   localparam int unsigned DataWidth = 32;
   // Command word = {target, cpol, cpha, data}
   localparam int unsigned CmdWidth  = DataWidth + 3;

   localparam int unsigned FifoDepthDefault   = 8;
   localparam int unsigned SetupCyclesDefault = 2;
   localparam int unsigned GapCyclesDefault   = 4;
   localparam int unsigned TimeoutDefault     = 4096;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StTrig,
      StWait,
      StGap
   } state_e;

   typedef struct packed {
      logic                 target;
      logic                 cpol;
      logic                 cpha;
      logic [DataWidth-1:0] data;
   } cmd_t;

   function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: clk/rst (sync, active-high); wr/wdata push; rd pop;
//        rdata head of queue (holds the last popped word while empty); full, empty.
// A push while full is accepted only if a pop happens in the same cycle.
module sync_fifo #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             rd,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = (AW + 1)'(1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr_q;
   logic [AW:0]      rd_ptr_q;
   logic [WIDTH-1:0] last_q;
   logic             push;
   logic             pop;

   // Extra MSB tells full from empty when the index bits match.
   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign pop   = rd && !empty;
   assign push  = wr && (!full || pop);
   assign rdata = empty ? last_q : mem[rd_ptr_q[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         last_q   <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
            last_q   <= mem[rd_ptr_q[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push) begin
         mem[wr_ptr_q[AW-1:0]] <= wdata;
      end
   end

endmodule

// File: rtl/spi_cmd_sequencer.sv
// SPI command sequencer.
// Pops command words from a command FIFO, presents them to an SPI master
// (setup hold, one-cycle trigger), waits for a spi_valid rising edge, pushes the
// received word into a response FIFO, then idles for a gap before the next one.
// Ports:
//   CLK_IN, RST                       clock, synchronous active-high reset
//   cmd_data/target/cpol/cpha, cmd_wr command word and push; cmd_full
//   rsp_data, rsp_empty, rsp_rd        FWFT response queue
//   spi_din/target/cpol/cpha/trigger   to the SPI master
//   spi_dout, spi_valid                from the SPI master
//   busy                               not idle
//   cmd_ovf, rsp_ovf, timeout_err      sticky errors, cleared by err_clr
module spi_cmd_sequencer
   import spi_cmd_sequencer_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = FifoDepthDefault,
   parameter int unsigned SETUP_CYCLES = SetupCyclesDefault,
   parameter int unsigned GAP_CYCLES   = GapCyclesDefault,
   parameter int unsigned TIMEOUT      = TimeoutDefault
) (
   input  logic                 CLK_IN,
   input  logic                 RST,
   input  logic [DataWidth-1:0] cmd_data,
   input  logic                 cmd_target,
   input  logic                 cmd_cpol,
   input  logic                 cmd_cpha,
   input  logic                 cmd_wr,
   output logic                 cmd_full,
   output logic [DataWidth-1:0] rsp_data,
   output logic                 rsp_empty,
   input  logic                 rsp_rd,
   output logic [DataWidth-1:0] spi_din,
   output logic                 spi_target,
   output logic                 spi_cpol,
   output logic                 spi_cpha,
   output logic                 spi_trigger,
   input  logic [DataWidth-1:0] spi_dout,
   input  logic                 spi_valid,
   output logic                 busy,
   output logic                 cmd_ovf,
   output logic                 rsp_ovf,
   output logic                 timeout_err,
   input  logic                 err_clr
);

   localparam int unsigned CntW = $clog2(max3(SETUP_CYCLES, GAP_CYCLES, TIMEOUT) + 1);
   localparam logic [CntW-1:0] CntOne = CntW'(1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [CmdWidth-1:0] cmd_wdata;
   logic [CmdWidth-1:0] cmd_rdata;
   cmd_t              cmd_head;
   cmd_t              spi_cmd_q;
   logic              cmd_empty;
   logic              cmd_pop;
   logic              rsp_push;
   logic              rsp_full;
   logic              valid_prev_q;
   logic              valid_rise;
   logic              timeout_evt;
   logic              cmd_ovf_evt;
   logic              rsp_ovf_evt;
   logic              cmd_ovf_q, rsp_ovf_q, timeout_err_q;

   assign cmd_wdata = {cmd_target, cmd_cpol, cmd_cpha, cmd_data};
   assign cmd_head  = cmd_t'(cmd_rdata);

   sync_fifo #(
      .WIDTH (CmdWidth),
      .DEPTH (FIFO_DEPTH)
   ) u_cmd_fifo (
      .clk   (CLK_IN),
      .rst   (RST),
      .wr    (cmd_wr),
      .wdata (cmd_wdata),
      .rd    (cmd_pop),
      .rdata (cmd_rdata),
      .full  (cmd_full),
      .empty (cmd_empty)
   );

   sync_fifo #(
      .WIDTH (DataWidth),
      .DEPTH (FIFO_DEPTH)
   ) u_rsp_fifo (
      .clk   (CLK_IN),
      .rst   (RST),
      .wr    (rsp_push),
      .wdata (spi_dout),
      .rd    (rsp_rd),
      .rdata (rsp_data),
      .full  (rsp_full),
      .empty (rsp_empty)
   );

   // valid_prev_q is sampled every cycle, so a level already high in TRIG is
   // not seen as an edge in the first WAIT cycle.
   assign valid_rise = spi_valid && !valid_prev_q;

   // A pop in the same cycle frees the slot, so only then is a full push safe.
   assign cmd_ovf_evt = cmd_wr && cmd_full && !cmd_pop;
   assign rsp_ovf_evt = rsp_push && rsp_full && !rsp_rd;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      cmd_pop     = 1'b0;
      rsp_push    = 1'b0;
      timeout_evt = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (!cmd_empty) begin
               cmd_pop = 1'b1;
               cnt_d   = '0;
               state_d = StSetup;
            end
         end
         StSetup: begin
            if (cnt_q == CntW'(SETUP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = StTrig;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StTrig: begin
            cnt_d   = '0;
            state_d = StWait;
         end
         StWait: begin
            if (valid_rise) begin
               rsp_push = 1'b1;
               cnt_d    = '0;
               state_d  = StGap;
            end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
               timeout_evt = 1'b1;
               cnt_d       = '0;
               state_d     = StGap;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         StGap: begin
            if (cnt_q == CntW'(GAP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntOne;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge CLK_IN) begin
      if (RST) begin
         state_q       <= StIdle;
         cnt_q         <= '0;
         spi_cmd_q     <= '0;
         valid_prev_q  <= 1'b0;
         cmd_ovf_q     <= 1'b0;
         rsp_ovf_q     <= 1'b0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         valid_prev_q <= spi_valid;
         if (cmd_pop) begin
            spi_cmd_q <= cmd_head;
         end
         // A coincident error event beats err_clr.
         cmd_ovf_q     <= cmd_ovf_evt || (cmd_ovf_q && !err_clr);
         rsp_ovf_q     <= rsp_ovf_evt || (rsp_ovf_q && !err_clr);
         timeout_err_q <= timeout_evt || (timeout_err_q && !err_clr);
      end
   end

   assign spi_din     = spi_cmd_q.data;
   assign spi_target  = spi_cmd_q.target;
   assign spi_cpol    = spi_cmd_q.cpol;
   assign spi_cpha    = spi_cmd_q.cpha;
   assign spi_trigger = (state_q == StTrig);
   assign busy        = (state_q != StIdle);
   assign cmd_ovf     = cmd_ovf_q;
   assign rsp_ovf     = rsp_ovf_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Scoreboard bench for spi_cmd_sequencer: stimulus pushes expected triggers and
// responses into queues; monitors pop and compare when the DUT presents them.
module tb_spi_cmd_sequencer;

   localparam int unsigned Depth = 8;
   localparam int unsigned Setup = 2;
   localparam int unsigned Gap   = 4;
   localparam int unsigned Tmo   = 16;

   logic        clk, rst;
   logic [31:0] cmd_data;
   logic        cmd_target, cmd_cpol, cmd_cpha, cmd_wr, cmd_full;
   logic [31:0] rsp_data;
   logic        rsp_empty, rsp_rd;
   logic [31:0] spi_din;
   logic        spi_target, spi_cpol, spi_cpha, spi_trigger;
   logic [31:0] spi_dout;
   logic        spi_valid;
   logic        busy, cmd_ovf, rsp_ovf, timeout_err, err_clr;

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;
   int trig_count = 0;
   int last_trig_cyc = 0;
   int last_send_cyc = 0;
   bit trig_seen = 0;
   int model_mode = 0;  // 0 respond, 1 silent, 2 valid pre-held high

   logic [34:0] exp_trig[$];
   logic [31:0] exp_rsp[$];
   logic [31:0] model_rsp[$];

   logic [34:0] prev_f = '0;
   bit          prev_busy = 0;
   bit          prev_rst = 1;

   spi_cmd_sequencer #(
      .FIFO_DEPTH   (Depth),
      .SETUP_CYCLES (Setup),
      .GAP_CYCLES   (Gap),
      .TIMEOUT      (Tmo)
   ) dut (
      .CLK_IN      (clk),
      .RST         (rst),
      .cmd_data    (cmd_data),
      .cmd_target  (cmd_target),
      .cmd_cpol    (cmd_cpol),
      .cmd_cpha    (cmd_cpha),
      .cmd_wr      (cmd_wr),
      .cmd_full    (cmd_full),
      .rsp_data    (rsp_data),
      .rsp_empty   (rsp_empty),
      .rsp_rd      (rsp_rd),
      .spi_din     (spi_din),
      .spi_target  (spi_target),
      .spi_cpol    (spi_cpol),
      .spi_cpha    (spi_cpha),
      .spi_trigger (spi_trigger),
      .spi_dout    (spi_dout),
      .spi_valid   (spi_valid),
      .busy        (busy),
      .cmd_ovf     (cmd_ovf),
      .rsp_ovf     (rsp_ovf),
      .timeout_err (timeout_err),
      .err_clr     (err_clr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Caller sits at posedge+1; consecutive calls give back-to-back writes.
   task automatic send(input logic [34:0] c, input logic [31:0] r, input bit issue,
                       input bit respond);
      {cmd_target, cmd_cpol, cmd_cpha, cmd_data} = c;
      cmd_wr = 1'b1;
      last_send_cyc = cyc;
      if (issue) exp_trig.push_back(c);
      if (respond) begin
         exp_rsp.push_back(r);
         model_rsp.push_back(r);
      end
      tick();
      cmd_wr = 1'b0;
   endtask

   task automatic wait_trig(input int start, input int bound);
      int n = 0;
      while (trig_count == start && n < bound) begin
         tick();
         n++;
      end
      chk("trigger_within_bound", trig_count != start, 1);
   endtask

   task automatic wait_idle(input int bound);
      int n = 0;
      while ((exp_trig.size() != 0 || exp_rsp.size() != 0 || busy) && n < bound) begin
         tick();
         n++;
      end
      chk("drain_within_bound", n < bound, 1);
   endtask

   // Trigger monitor: fields, spacing, pulse ordering.
   initial begin
      logic [34:0] e;
      forever begin
         @(negedge clk);
         if (spi_trigger) begin
            if (trig_seen) chk("trig_spacing_ok", (cyc - last_trig_cyc) >= (Gap + Setup + 1), 1);
            chk("trigger_expected", exp_trig.size() != 0, 1);
            if (exp_trig.size() != 0) begin
               e = exp_trig.pop_front();
               chk("trig_fields", {spi_target, spi_cpol, spi_cpha, spi_din}, e);
            end
            trig_seen = 1;
            last_trig_cyc = cyc;
            trig_count++;
         end
      end
   end

   // Response monitor: compare head, then pop it.
   initial begin
      rsp_rd = 1'b0;
      forever begin
         @(negedge clk);
         rsp_rd = 1'b0;
         if (!rsp_empty && !rst) begin
            chk("response_expected", exp_rsp.size() != 0, 1);
            if (exp_rsp.size() != 0) chk("rsp_data", rsp_data, exp_rsp.pop_front());
            rsp_rd = 1'b1;
         end
      end
   end

   // spi_* fields may only change when leaving IDLE.
   initial begin
      forever begin
         @(negedge clk);
         if (!prev_rst && ({spi_target, spi_cpol, spi_cpha, spi_din} != prev_f))
            chk("spi_fields_held_while_busy", prev_busy, 0);
         prev_f    = {spi_target, spi_cpol, spi_cpha, spi_din};
         prev_busy = busy;
         prev_rst  = rst;
      end
   end

   // SPI master model.
   initial begin
      logic [31:0] r;
      spi_valid = 1'b0;
      spi_dout  = '0;
      forever begin
         @(negedge clk);
         if (!spi_trigger) begin
            spi_valid = (model_mode == 2);
         end else if (model_mode != 1) begin
            r = (model_rsp.size() != 0) ? model_rsp.pop_front() : 32'hdead_beef;
            if (model_mode == 2) begin
               repeat (4) @(negedge clk);
               spi_valid = 1'b0;
               repeat (2) @(negedge clk);
            end else begin
               repeat (2) @(negedge clk);
            end
            spi_dout  = r;
            spi_valid = 1'b1;
            @(negedge clk);
            spi_valid = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, checks=%0d", checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t;
      rst = 1'b1; cmd_wr = 1'b0; err_clr = 1'b0;
      cmd_data = '0; cmd_target = 1'b0; cmd_cpol = 1'b0; cmd_cpha = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_cmd_full", cmd_full, 0);
      chk("reset_rsp_empty", rsp_empty, 1);
      chk("reset_spi_din", spi_din, 0);
      chk("reset_spi_mode", {spi_target, spi_cpol, spi_cpha}, 0);
      chk("reset_trigger", spi_trigger, 0);
      chk("reset_errors", {cmd_ovf, rsp_ovf, timeout_err}, 0);
      tick();

      // Single command, latency and response.
      model_mode = 0;
      t = trig_count;
      send({1'b1, 1'b0, 1'b0, 32'haaaa3333}, 32'h12345678, 1, 1);
      wait_trig(t, 20);
      chk("trig_latency", last_trig_cyc - last_send_cyc, Setup + 2);
      wait_idle(60);
      chk("single_trigger_count", trig_count - t, 1);
      chk("rsp_hold_after_pop", rsp_data, 32'h12345678);

      // Four back-to-back commands, all SPI modes.
      send({1'b0, 1'b0, 1'b0, 32'h1111_0001}, 32'hc0de_0001, 1, 1);
      send({1'b1, 1'b0, 1'b1, 32'h2222_0002}, 32'hc0de_0002, 1, 1);
      send({1'b0, 1'b1, 1'b1, 32'h3333_0003}, 32'hc0de_0003, 1, 1);
      send({1'b1, 1'b1, 1'b0, 32'h4444_0004}, 32'hc0de_0004, 1, 1);
      wait_idle(200);
      chk("no_errors_after_burst", {cmd_ovf, rsp_ovf, timeout_err}, 0);

      // Fill the command FIFO while the model is stalled.
      model_mode = 1;
      send({1'b0, 1'b0, 1'b0, 32'h5000_0000}, 32'h0, 1, 0);
      for (int i = 0; i < 10 && !busy; i++) tick();
      chk("busy_after_pop", busy, 1);
      for (int i = 0; i < 8; i++)
         send({i[0], i[1], i[2], 32'h5000_0001 + i}, 32'h0, 1, 0);
      @(negedge clk);
      chk("cmd_full_at_8", cmd_full, 1);
      chk("cmd_ovf_before_9th", cmd_ovf, 0);
      tick();
      send({1'b1, 1'b1, 1'b1, 32'hbad0_0009}, 32'h0, 0, 0);
      @(negedge clk);
      chk("cmd_ovf_set", cmd_ovf, 1);
      chk("cmd_full_still", cmd_full, 1);
      tick();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      chk("cmd_ovf_cleared", cmd_ovf, 0);
      tick();
      wait_idle(400);
      chk("timeout_err_after_stall", timeout_err, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      @(negedge clk);
      chk("timeout_err_cleared", timeout_err, 0);
      tick();

      // Timeout after exactly Tmo WAIT cycles, then a normal command.
      t = trig_count;
      send({1'b0, 1'b1, 1'b0, 32'h6666_0006}, 32'h0, 1, 0);
      wait_trig(t, 20);
      t = last_trig_cyc;
      for (int i = 0; i < 40 && cyc < t + Tmo; i++) tick();
      @(negedge clk);
      chk("timeout_not_yet", timeout_err, 0);
      @(negedge clk);
      chk("timeout_set", timeout_err, 1);
      model_mode = 0;
      tick();
      send({1'b1, 1'b0, 1'b1, 32'h7777_0007}, 32'hfeed_0007, 1, 1);
      wait_idle(80);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;

      // spi_valid high before trigger must not complete the transaction.
      model_mode = 2;
      t = trig_count;
      send({1'b0, 1'b0, 1'b1, 32'h8888_0008}, 32'hbeef_0008, 1, 1);
      wait_trig(t, 20);
      repeat (4) tick();
      @(negedge clk);
      chk("held_valid_ignored", exp_rsp.size(), 1);
      chk("held_valid_still_busy", busy, 1);
      tick();
      wait_idle(80);
      model_mode = 0;
      tick();

      // Reset during WAIT with commands queued.
      model_mode = 1;
      t = trig_count;
      send({1'b1, 1'b0, 1'b0, 32'h9999_0001}, 32'h0, 1, 0);
      send({1'b0, 1'b0, 1'b0, 32'h9999_0002}, 32'h0, 0, 0);
      send({1'b0, 1'b0, 1'b0, 32'h9999_0003}, 32'h0, 0, 0);
      send({1'b0, 1'b0, 1'b0, 32'h9999_0004}, 32'h0, 0, 0);
      wait_trig(t, 20);
      repeat (3) tick();
      rst = 1'b1;
      {cmd_target, cmd_cpol, cmd_cpha, cmd_data} = {3'b111, 32'h9999_00ff};
      cmd_wr = 1'b1;
      tick();
      rst = 1'b0;
      cmd_wr = 1'b0;
      @(negedge clk);
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_rsp_empty", rsp_empty, 1);
      chk("rst_mid_cmd_full", cmd_full, 0);
      chk("rst_mid_spi_out", {spi_target, spi_cpol, spi_cpha, spi_din, spi_trigger}, 0);
      chk("rst_mid_errors", {cmd_ovf, rsp_ovf, timeout_err}, 0);
      t = trig_count;
      repeat (60) tick();
      chk("no_trigger_after_rst", trig_count - t, 0);
      chk("idle_after_rst", busy, 0);
      chk("queues_empty", exp_trig.size() + exp_rsp.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/spi_cmd_sequencer.md
SPI_CMD_SEQUENCER -- requirements
Module: spi_cmd_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, entries in each of the command and response FIFOs (power of 2, >=2).
REQ-002 Parameter SETUP_CYCLES, default 2, cycles spi_cpol/spi_cpha/spi_target/spi_din are held stable before the trigger pulse.
REQ-003 Parameter GAP_CYCLES, default 4, idle cycles after a completed transaction before the next one starts.
REQ-004 Parameter TIMEOUT, default 4096, maximum WAIT cycles before a transaction is abandoned.
REQ-005 CLK_IN  in  1  single system clock; all logic is on the rising edge.
REQ-006 RST  in  1  reset; synchronous, active-high.
REQ-007 cmd_data  in  32, cmd_target  in  1, cmd_cpol  in  1, cmd_cpha  in  1: fields of the command word.
REQ-008 cmd_wr  in  1  push the command word; cmd_full  out  1  command FIFO full.
REQ-009 rsp_data  out  32  head of the response FIFO (first-word fall-through); rsp_empty  out  1; rsp_rd  in  1  pop.
REQ-010 spi_din  out  32, spi_target  out  1, spi_cpol  out  1, spi_cpha  out  1, spi_trigger  out  1: drive the SPI master.
REQ-011 spi_dout  in  32, spi_valid  in  1: received word and completion from the SPI master.
REQ-012 busy  out  1  high in any state except IDLE.
REQ-013 cmd_ovf, rsp_ovf, timeout_err  out  1 each, sticky error flags; err_clr  in  1  clears all three.

Function
REQ-014 FSM states: IDLE, SETUP, TRIG, WAIT, GAP.
REQ-015 IDLE with the command FIFO non-empty: pop the head, register it onto the spi_* outputs, and enter SETUP on the next edge.
REQ-016 SETUP lasts exactly SETUP_CYCLES cycles, then TRIG.
REQ-017 TRIG lasts one cycle with spi_trigger=1; spi_trigger SHALL be 0 in every other state; next state is WAIT.
REQ-018 The spi_din, spi_target, spi_cpol and spi_cpha outputs SHALL remain constant from SETUP entry until the transaction leaves WAIT.
REQ-019 WAIT completes only on a spi_valid 0->1 edge detected in WAIT; a level already high at WAIT entry SHALL be ignored.
REQ-020 On completion, push spi_dout into the response FIFO and go to GAP; if the response FIFO is full, drop the word and set rsp_ovf.
REQ-021 If WAIT reaches TIMEOUT cycles without completion: set timeout_err, push nothing, and go to GAP.
REQ-022 GAP lasts GAP_CYCLES cycles, then IDLE.
REQ-023 Minimum command-to-trigger latency: cmd_wr at edge N into an empty, idle block yields spi_trigger high during cycle N+2+SETUP_CYCLES.
REQ-024 cmd_wr while cmd_full: the word is dropped and cmd_ovf is set; the FIFO content is unchanged.
REQ-025 rsp_rd while rsp_empty is ignored; rsp_data is undefined-free (holds its last value).
REQ-026 Simultaneous push and pop on either FIFO both take effect; occupancy is unchanged, including at full (pop frees the slot the push uses).
REQ-027 FIFO pointers wrap modulo FIFO_DEPTH; full/empty are distinguished by an extra pointer bit.
REQ-028 If err_clr and an error event coincide, the event wins and the flag is set.
REQ-029 Commands are issued strictly in FIFO order; responses are pushed in the same order.

Reset
REQ-030 RST SHALL, on the next edge: set state IDLE, empty both FIFOs, and zero spi_din/spi_target/spi_cpol/spi_cpha/spi_trigger/busy and all error flags; cmd_full=0, rsp_empty=1.
REQ-031 RST asserted mid-transaction abandons it without pushing a response; cmd_wr/rsp_rd during RST are ignored.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding, the command-word field widths, and the parameter defaults.
REQ-033 A single sub-module, sync_fifo (parameterised width/depth, FWFT, full/empty), SHALL be instantiated twice: 35-bit command and 32-bit response.

Verification
REQ-034 Single command 32'haaaa3333, target=1, CPOL=0, CPHA=0; model returns 32'h12345678 -> exactly one spi_trigger pulse at the REQ-023 cycle; rsp_data=32'h12345678.
REQ-035 Four back-to-back commands, modes (0,0),(0,1),(1,1),(1,0) -> four triggers separated by >=GAP_CYCLES+SETUP_CYCLES+1 cycles; responses in order; CPOL/CPHA stable from SETUP through WAIT.
REQ-036 Nine cmd_wr with the model stalled, FIFO_DEPTH=8 -> after the first is popped, eight are buffered; the ninth pushed while cmd_full=1 sets cmd_ovf; err_clr clears it.
REQ-037 Model never asserts spi_valid, TIMEOUT=16 -> timeout_err=1 after 16 WAIT cycles, no response pushed, next command proceeds.
REQ-038 spi_valid held high before trigger -> no completion until it falls and rises again.
REQ-039 RST pulsed during WAIT with 3 commands queued -> IDLE, both FIFOs empty, and no further spi_trigger.
